fft64_twiddle_mult: RTL and testbench

// - Inter-stage twiddle multiplier for the 8x8 (radix-8 x radix-8) FFT64: streaming, one complex sample/clk.
// - Sits directly downstream of the 8-deep reorder shift registers.
// - Input sample i of a 64-sample frame has row r=i[5:3], col c=i[2:0].
// - Output = din * W64^(r*c), with W64 = exp(-j*2*pi/64).
// - Feeds the second radix-8 butterfly stage; no backpressure anywhere in the datapath.

---
 rtl/fft64_pkg.sv | 73 +++++++
 rtl/fft64_tw_rom.sv | 34 +++
 rtl/fft64_twiddle_mult.sv | 113 +++++++++++
 tb/tb_fft64_twiddle_mult.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fft64_pkg.sv
// Shared constants, twiddle tables and helpers for the FFT64 inter-stage twiddle multiplier.
package fft64_pkg;

    localparam int unsigned DW   = 10;
    localparam int unsigned TW   = 10;
    localparam int unsigned FRAC = 8;
    localparam int unsigned PW   = DW + TW;  // product width
    localparam int unsigned SW   = PW + 1;   // complex sum width

    typedef logic signed [TW-1:0] tw_t;
    typedef tw_t tw_tab_t [64];

    // round(256*cos(2*pi*k/64)), k = 0..16
    localparam tw_t COS_Q [17] = '{
        10'sd256, 10'sd255, 10'sd251, 10'sd245, 10'sd237, 10'sd226, 10'sd213, 10'sd198,
        10'sd181, 10'sd162, 10'sd142, 10'sd121, 10'sd98,  10'sd74,  10'sd50,  10'sd25,
        10'sd0
    };

    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (DW - 1)));
    localparam logic signed [SW-1:0] RND     = SW'(2 ** (FRAC - 1));

    // Real part of W64^e, unfolded from the quarter-wave table.
    function automatic tw_t tw_cos(input logic [5:0] e);
        logic [4:0] m;
        logic [4:0] mc;
        m  = {1'b0, e[3:0]};
        mc = 5'd16 - m;
        case (e[5:4])
            2'd0:    return COS_Q[m];
            2'd1:    return -COS_Q[mc];
            2'd2:    return -COS_Q[m];
            default: return COS_Q[mc];
        endcase
    endfunction

    // Imaginary part of W64^e, i.e. -sin.
    function automatic tw_t tw_nsin(input logic [5:0] e);
        logic [4:0] m;
        logic [4:0] mc;
        m  = {1'b0, e[3:0]};
        mc = 5'd16 - m;
        case (e[5:4])
            2'd0:    return -COS_Q[mc];
            2'd1:    return -COS_Q[m];
            2'd2:    return COS_Q[mc];
            default: return COS_Q[m];
        endcase
    endfunction

    function automatic tw_tab_t build_wr_tab();
        tw_tab_t t;
        for (int k = 0; k < 64; k++) t[k] = tw_cos(6'(k));
        return t;
    endfunction

    function automatic tw_tab_t build_wi_tab();
        tw_tab_t t;
        for (int k = 0; k < 64; k++) t[k] = tw_nsin(6'(k));
        return t;
    endfunction

    localparam tw_tab_t WR_TAB = build_wr_tab();
    localparam tw_tab_t WI_TAB = build_wi_tab();

    function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] x);
        if (x > SAT_MAX) return SAT_MAX[DW-1:0];
        if (x < SAT_MIN) return SAT_MIN[DW-1:0];
        return x[DW-1:0];
    endfunction

endpackage

// File: rtl/fft64_tw_rom.sv
// Twiddle ROM: exponent in, registered W64^e out one clock later.
// FFT64_TW_QUARTER_ROM_EN selects the 17-entry quarter-wave table instead of full 64-entry tables.
module fft64_tw_rom
    import fft64_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] e,
    output tw_t        wr,
    output tw_t        wi
);

    tw_t wr_d;
    tw_t wi_d;

`ifdef FFT64_TW_QUARTER_ROM_EN
    assign wr_d = tw_cos(e);
    assign wi_d = tw_nsin(e);
`else
    assign wr_d = WR_TAB[e];
    assign wi_d = WI_TAB[e];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr <= '0;
            wi <= '0;
        end else begin
            wr <= wr_d;
            wi <= wi_d;
        end
    end

endmodule

// File: rtl/fft64_twiddle_mult.sv
// FFT64 inter-stage twiddle multiplier: dout = din * W64^(r*c), streaming, 3-clock latency.
// Build option FFT64_TW_QUARTER_ROM_EN picks the quarter-wave ROM (see fft64_tw_rom).
module fft64_twiddle_mult
    import fft64_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic signed [DW-1:0] din_re,
    input  logic signed [DW-1:0] din_im,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic signed [DW-1:0] dout_re,
    output logic signed [DW-1:0] dout_im
);

    logic [5:0] idx_q;
    logic [5:0] cur_idx;
    logic [5:0] e;

    // in_sof restarts the frame on the current sample itself
    assign cur_idx = in_sof ? 6'd0 : idx_q;
    assign e       = {3'b000, cur_idx[5:3]} * {3'b000, cur_idx[2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (in_valid) begin
            idx_q <= cur_idx + 6'd1;
        end
    end

    // S1: sample register alongside the registered ROM output
    logic                 v1_q;
    logic                 sof1_q;
    logic signed [DW-1:0] ar1_q;
    logic signed [DW-1:0] ai1_q;
    tw_t                  wr;
    tw_t                  wi;

    fft64_tw_rom u_tw_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .e     (e),
        .wr    (wr),
        .wi    (wi)
    );

    // S2: partial products
    logic                 v2_q;
    logic                 sof2_q;
    logic signed [PW-1:0] p_rr_q;
    logic signed [PW-1:0] p_ii_q;
    logic signed [PW-1:0] p_ri_q;
    logic signed [PW-1:0] p_ir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            sof1_q <= 1'b0;
            ar1_q  <= '0;
            ai1_q  <= '0;
            v2_q   <= 1'b0;
            sof2_q <= 1'b0;
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
        end else begin
            v1_q   <= in_valid;
            sof1_q <= in_valid & in_sof;
            ar1_q  <= din_re;
            ai1_q  <= din_im;
            v2_q   <= v1_q;
            sof2_q <= sof1_q;
            p_rr_q <= ar1_q * wr;
            p_ii_q <= ai1_q * wi;
            p_ri_q <= ar1_q * wi;
            p_ir_q <= ai1_q * wr;
        end
    end

    // S3: combine, round half-up, scale and clamp
    logic signed [SW-1:0] re_sum;
    logic signed [SW-1:0] im_sum;
    logic signed [SW-1:0] re_shr;
    logic signed [SW-1:0] im_shr;

    always_comb begin
        re_sum = $signed({p_rr_q[PW-1], p_rr_q}) - $signed({p_ii_q[PW-1], p_ii_q});
        im_sum = $signed({p_ri_q[PW-1], p_ri_q}) + $signed({p_ir_q[PW-1], p_ir_q});
        re_shr = (re_sum + RND) >>> FRAC;
        im_shr = (im_sum + RND) >>> FRAC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            dout_re   <= '0;
            dout_im   <= '0;
        end else begin
            out_valid <= v2_q;
            out_sof   <= sof2_q;
            if (v2_q) begin
                dout_re <= sat(re_shr);
                dout_im <= sat(im_shr);
            end
        end
    end

endmodule

// File: tb/tb_fft64_twiddle_mult.sv
// Self-checking bench for fft64_twiddle_mult against a real-arithmetic reference model.
module tb_fft64_twiddle_mult;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [9:0] din_re = '0;
    logic [9:0] din_im = '0;
    logic       out_valid;
    logic       out_sof;
    logic [9:0] dout_re;
    logic [9:0] dout_im;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit v;
        bit sof;
        int re;
        int im;
    } exp_t;

    exp_t q[$];
    int   m_idx = 0;
    int   hold_re = 0;
    int   hold_im = 0;

    fft64_twiddle_mult dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .din_re    (din_re),
        .din_im    (din_im),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .dout_re   (dout_re),
        .dout_im   (dout_im)
    );

    always #5 clk = ~clk;

    function automatic int rnd(real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic int clamp(int x);
        return (x > 511) ? 511 : ((x < -512) ? -512 : x);
    endfunction

    function automatic int rand_s();
        return int'($urandom_range(1023)) - 512;
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(want));
        end
    endtask

    // Pipeline was just emptied: two idle slots precede the first new sample.
    task automatic model_reset();
        exp_t idle;
        idle = '{v: 1'b0, sof: 1'b0, re: 0, im: 0};
        q.delete();
        q.push_back(idle);
        q.push_back(idle);
        m_idx   = 0;
        hold_re = 0;
        hold_im = 0;
    endtask

    // One clock: drive inputs, predict, advance, then compare the sample due now.
    task automatic cycle(input bit v, input bit sof, input int re, input int im,
                         input bit fx, input int er, input int ei);
        exp_t ex;
        int   cur;
        int   ee;
        int   wr;
        int   wi;
        real  ang;
        in_valid = v;
        in_sof   = sof;
        din_re   = 10'(re);
        din_im   = 10'(im);
        ex = '{v: v, sof: v & sof, re: 0, im: 0};
        if (v) begin
            cur   = sof ? 0 : m_idx;
            m_idx = (cur + 1) % 64;
            ee    = (cur / 8) * (cur % 8);
            ang   = 2.0 * 3.14159265358979 * real'(ee) / 64.0;
            wr    = rnd(256.0 * $cos(ang));
            wi    = rnd(-256.0 * $sin(ang));
            ex.re = clamp((re * wr - im * wi + 128) >>> 8);
            ex.im = clamp((re * wi + im * wr + 128) >>> 8);
            if (fx) begin
                ex.re = er;
                ex.im = ei;
            end
        end
        q.push_back(ex);
        @(posedge clk);
        #1;
        ex = q.pop_front();
        if (ex.v) begin
            hold_re = ex.re;
            hold_im = ex.im;
        end
        chk("out_valid", 10'(out_valid), 10'(ex.v));
        chk("out_sof", 10'(out_sof), 10'(ex.sof));
        chk("dout_re", dout_re, 10'(hold_re));
        chk("dout_im", dout_im, 10'(hold_im));
    endtask

    task automatic smp(input bit v, input bit sof, input int re, input int im);
        cycle(v, sof, re, im, 1'b0, 0, 0);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, $urandom_range(1) == 1, rand_s(), rand_s(), 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        chk("rst_out_valid", 10'(out_valid), 10'd0);
        chk("rst_out_sof", 10'(out_sof), 10'd0);
        chk("rst_dout_re", dout_re, 10'd0);
        chk("rst_dout_im", dout_im, 10'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        do_reset();

        // Row 0 passthrough
        for (int i = 0; i < 8; i++) cycle(1'b1, i == 0, 100, -50, 1'b1, 100, -50);
        for (int i = 0; i < 3; i++) smp(1'b0, 1'b0, 0, 0);

        // i=20 rounding and i=36 -j in one frame
        smp(1'b1, 1'b1, rand_s(), rand_s());
        for (int i = 1; i < 20; i++) smp(1'b1, 1'b0, rand_s(), rand_s());
        cycle(1'b1, 1'b0, 3, 0, 1'b1, 2, -2);
        for (int i = 21; i < 36; i++) smp(1'b1, 1'b0, rand_s(), rand_s());
        cycle(1'b1, 1'b0, 100, 50, 1'b1, 50, -100);

        // Saturation at i=20
        smp(1'b1, 1'b1, rand_s(), rand_s());
        for (int i = 1; i < 20; i++) smp(1'b1, 1'b0, rand_s(), rand_s());
        cycle(1'b1, 1'b0, -512, -512, 1'b1, -512, 0);
        for (int i = 0; i < 4; i++) idle_cycle();

        // Random gaps with a mid-frame restart at i=10
        for (int k = 0; k < 140; k++) begin
            if ($urandom_range(3) == 0) begin
                for (int g = 0; g < int'($urandom_range(3, 1)); g++) idle_cycle();
            end
            smp(1'b1, (k == 0) || (k == 10) || (k == 74), rand_s(), rand_s());
        end

        // Reset with samples in flight, then resume without in_sof
        do_reset();
        for (int i = 0; i < 16; i++) smp(1'b1, 1'b0, rand_s(), rand_s());
        for (int i = 0; i < 4; i++) idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
